// File: rtl/gvizi_regmap_pkg.sv
// Register-map constants shared by the SPI write and read-back paths.
// Holds the address map, frame geometry, read-back FSM states and the debug view.
package gvizi_regmap_pkg;

    localparam logic [15:0] VERSION    = 16'h0001;
    localparam int          FRAME_W    = 24;
    localparam int          R_FLAG_BIT = 23;
    localparam int          CNT_W      = 5;

    localparam logic [3:0] ADDR_VERSION = 4'd0;
    localparam logic [3:0] ADDR_CHEN    = 4'd1;
    localparam logic [3:0] ADDR_MODE    = 4'd2;
    localparam logic [3:0] ADDR_CNT0    = 4'd3;
    localparam logic [3:0] ADDR_DAC0    = 4'd4;
    localparam logic [3:0] ADDR_CNT1    = 4'd5;
    localparam logic [3:0] ADDR_DAC1    = 4'd6;
    localparam logic [3:0] ADDR_CNT2    = 4'd7;
    localparam logic [3:0] ADDR_DAC2    = 4'd8;
    localparam logic [3:0] ADDR_CNT3    = 4'd9;
    localparam logic [3:0] ADDR_DAC3    = 4'd10;
    localparam logic [3:0] ADDR_PRESC   = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] bit_cnt;
        logic             sclk_lvl;
        logic             sclk_rise;
        logic             cs_n_lvl;
    } dbg_t;

    // R flag in the MSB, three reserved zeros, then address and data.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [3:0] addr,
                                                      input logic [15:0] data);
        return {1'b1, 3'b000, addr, data};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop for an asynchronous pin, with
// registered rise/fall strobes and a level that is time-aligned to them.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            hist <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            hist <= sync;
            rise <= sync & ~hist;
            fall <= ~sync & hist;
        end
    end

    // hist carries the new value on the same cycle the strobe fires.
    assign level = hist;

endmodule

// File: rtl/spi_readback_tx.sv
// SPI read-back transmitter: snapshots an addressed register on request and
// shifts a 24-bit response frame out MSB-first on the master's SCLK falling edges.
module spi_readback_tx
    import gvizi_regmap_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_rd_req,
    input  logic [3:0]  i_rd_addr,
    input  logic        i_mod,
    input  logic        i_Clk_mod,
    input  logic [7:0]  i_presc,
    input  logic [3:0]  i_ChEnable,
    input  logic [15:0] i_ChCountD0,
    input  logic [15:0] i_ChCountD1,
    input  logic [15:0] i_ChCountD2,
    input  logic [15:0] i_ChCountD3,
    input  logic [7:0]  i_ChDacD0,
    input  logic [7:0]  i_ChDacD1,
    input  logic [7:0]  i_ChDacD2,
    input  logic [7:0]  i_ChDacD3,
    output logic        o_miso,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_abort,
    output dbg_t        o_dbg
);

    // Request handshake: i_rd_req is a one-cycle valid with no ready; the
    // implicit ready is ~o_busy, and a request seen while busy is dropped.

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_n_lvl, cs_rise, cs_fall;

    sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .pin   (i_sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .pin   (i_cs_n),
        .level (cs_n_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    logic [15:0]        rd_data;
    logic [FRAME_W-1:0] frame_c;

    always_comb begin
        rd_data = 16'h0000;
        case (i_rd_addr)
            ADDR_VERSION: rd_data = VERSION;
            ADDR_CHEN:    rd_data = {4'b0000, i_ChEnable, 8'h00};
            ADDR_MODE:    rd_data = {11'b0, i_Clk_mod, 3'b000, i_mod};
            ADDR_CNT0:    rd_data = i_ChCountD0;
            ADDR_DAC0:    rd_data = {8'h00, i_ChDacD0};
            ADDR_CNT1:    rd_data = i_ChCountD1;
            ADDR_DAC1:    rd_data = {8'h00, i_ChDacD1};
            ADDR_CNT2:    rd_data = i_ChCountD2;
            ADDR_DAC2:    rd_data = {8'h00, i_ChDacD2};
            ADDR_CNT3:    rd_data = i_ChCountD3;
            ADDR_DAC3:    rd_data = {8'h00, i_ChDacD3};
            ADDR_PRESC:   rd_data = {8'h00, i_presc};
            default:      rd_data = 16'h0000;
        endcase
        frame_c = pack_frame(i_rd_addr, rd_data);
    end

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic               miso_q, miso_nxt;
    logic               done_q, done_nxt;
    logic               abort_q, abort_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            miso_q  <= miso_nxt;
            done_q  <= done_nxt;
            abort_q <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        miso_nxt    = miso_q;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;
        case (state)
            IDLE: begin
                miso_nxt = 1'b0;
                if (i_rd_req) begin
                    shreg_nxt   = frame_c;
                    bit_cnt_nxt = '0;
                    state_nxt   = ARMED;
                end
            end
            ARMED: begin
                if (cs_rise) begin
                    abort_nxt = 1'b1;
                    miso_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (!cs_n_lvl || cs_fall) begin
                    miso_nxt  = shreg[R_FLAG_BIT];
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // The last falling edge outranks a simultaneous CS release.
                if (sclk_fall && bit_cnt == LAST_BIT) begin
                    shreg_nxt   = {shreg[FRAME_W-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    miso_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end else if (cs_rise) begin
                    abort_nxt = 1'b1;
                    miso_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (sclk_fall) begin
                    shreg_nxt   = {shreg[FRAME_W-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    miso_nxt    = shreg[FRAME_W-2];
                end
            end
            default: begin
                miso_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_miso  = miso_q;
    assign o_busy  = (state != IDLE);
    assign o_done  = done_q;
    assign o_abort = abort_q;

    always_comb begin
        o_dbg           = '0;
        o_dbg.state     = state;
        o_dbg.bit_cnt   = bit_cnt;
        o_dbg.sclk_lvl  = sclk_lvl;
        o_dbg.sclk_rise = sclk_rise;
        o_dbg.cs_n_lvl  = cs_n_lvl;
    end

endmodule

// File: tb/tb_spi_readback_tx.sv
// Bench for spi_readback_tx: an SPI master model reads frames back and compares
// them with frames computed from the register map in plain arithmetic.
module tb_spi_readback_tx;
    import gvizi_regmap_pkg::*;

    localparam int HALF = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        rd_req = 1'b0;
    logic [3:0]  rd_addr = 4'd0;
    logic        mod_r = 1'b0;
    logic        clk_mod_r = 1'b0;
    logic [7:0]  presc_r = 8'd0;
    logic [3:0]  chen_r = 4'd0;
    logic [15:0] cnt_r [4];
    logic [7:0]  dac_r [4];
    logic        miso, busy, done, abort_p;
    dbg_t        dbg;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    logic [23:0] exp_q[$];

    spi_readback_tx dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sclk      (sclk),
        .i_cs_n      (cs_n),
        .i_rd_req    (rd_req),
        .i_rd_addr   (rd_addr),
        .i_mod       (mod_r),
        .i_Clk_mod   (clk_mod_r),
        .i_presc     (presc_r),
        .i_ChEnable  (chen_r),
        .i_ChCountD0 (cnt_r[0]),
        .i_ChCountD1 (cnt_r[1]),
        .i_ChCountD2 (cnt_r[2]),
        .i_ChCountD3 (cnt_r[3]),
        .i_ChDacD0   (dac_r[0]),
        .i_ChDacD1   (dac_r[1]),
        .i_ChDacD2   (dac_r[2]),
        .i_ChDacD3   (dac_r[3]),
        .o_miso      (miso),
        .o_busy      (busy),
        .o_done      (done),
        .o_abort     (abort_p),
        .o_dbg       (dbg)
    );

    // Pulse monitor; busy must already be low in the cycle done is high.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_at_done: got %b want 0", busy);
            end
        end
        if (abort_p) abort_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [23:0] ref_frame(input int addr);
        logic [15:0] map [16];
        for (int i = 0; i < 16; i++) map[i] = 16'h0000;
        map[0]  = 16'h0001;
        map[1]  = 16'(chen_r) * 16'd256;
        map[2]  = 16'(clk_mod_r) * 16'd16 + 16'(mod_r);
        for (int ch = 0; ch < 4; ch++) begin
            map[3 + 2 * ch] = cnt_r[ch];
            map[4 + 2 * ch] = 16'(dac_r[ch]);
        end
        map[11] = 16'(presc_r);
        return 24'h800000 + 24'(addr) * 24'h010000 + 24'(map[addr]);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_request(input logic [3:0] addr);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = addr;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic spi_read(input int nbits, output logic [23:0] rx);
        rx = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            rx = {rx[22:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Full transaction: request, busy check, 24-bit read, scoreboard and pulse checks.
    task automatic read_and_check(input logic [3:0] addr, input string name);
        logic [23:0] rx, exp;
        int d0, a0;
        exp_q.push_back(ref_frame(int'(addr)));
        d0 = done_cnt;
        a0 = abort_cnt;
        do_request(addr);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_after_req: got %b want 1", name, busy);
        end
        spi_read(24, rx);
        exp = exp_q.pop_front();
        checks++;
        if (rx !== exp) begin
            failures++;
            $display("FAIL %s_frame: got %h want %h", name, rx, exp);
        end
        checks++;
        if (done_cnt - d0 != 1 || abort_cnt != a0) begin
            failures++;
            $display("FAIL %s_pulses: done=%0d abort=%0d want done=1 abort=0",
                     name, done_cnt - d0, abort_cnt - a0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_end: got %b want 0", name, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg.state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d want %0d", dbg.state, IDLE);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({miso, busy, done, abort_p} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle_outputs: got %b want 0000",
                         {miso, busy, done, abort_p});
            end
        end
    endtask

    task automatic test_directed();
        logic [23:0] rx;
        cnt_r[2] = 16'hA5C3;
        mod_r = 1'b1;
        clk_mod_r = 1'b1;
        read_and_check(4'd7, "cnt2");
        do_request(4'd2);
        spi_read(24, rx);
        checks++;
        if (rx !== 24'h820011) begin
            failures++;
            $display("FAIL mode_frame: got %h want 820011", rx);
        end
        do_request(4'd13);
        spi_read(24, rx);
        checks++;
        if (rx !== 24'h8D0000) begin
            failures++;
            $display("FAIL addr13_frame: got %h want 8d0000", rx);
        end
        do_request(4'd0);
        spi_read(24, rx);
        checks++;
        if (rx !== 24'h800001) begin
            failures++;
            $display("FAIL version_frame: got %h want 800001", rx);
        end
        do_request(4'd7);
        spi_read(24, rx);
        checks++;
        if (rx !== 24'h87A5C3) begin
            failures++;
            $display("FAIL cnt2_literal: got %h want 87a5c3", rx);
        end
    endtask

    task automatic test_snapshot();
        logic [23:0] rx;
        presc_r = 8'd3;
        do_request(4'd11);
        fork
            spi_read(24, rx);
            begin
                repeat (80) @(negedge clk);
                presc_r = 8'hFF;
            end
        join
        checks++;
        if (rx !== 24'h8B0003) begin
            failures++;
            $display("FAIL snapshot_frame: got %h want 8b0003", rx);
        end
    endtask

    task automatic test_abort();
        logic [23:0] rx;
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        do_request(4'd5);
        spi_read(10, rx);
        checks++;
        if (abort_cnt - a0 != 1 || done_cnt != d0) begin
            failures++;
            $display("FAIL abort_pulses: abort=%0d done=%0d want abort=1 done=0",
                     abort_cnt - a0, done_cnt - d0);
        end
        checks++;
        if (busy !== 1'b0 || miso !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: busy=%b miso=%b want 0 0", busy, miso);
        end
        cnt_r[1] = 16'($urandom);
        read_and_check(4'd5, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [23:0] rx, exp;
        cnt_r[3] = 16'h1234;
        exp = ref_frame(9);
        do_request(4'd9);
        fork
            spi_read(24, rx);
            begin
                repeat (100) @(negedge clk);
                do_request(4'd0);
                cnt_r[3] = 16'hFFFF;
            end
        join
        checks++;
        if (rx !== exp) begin
            failures++;
            $display("FAIL ignored_req_frame: got %h want %h", rx, exp);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_req_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] rx;
        int d0;
        d0 = done_cnt;
        do_request(4'd3);
        fork
            spi_read(24, rx);
            begin
                repeat (120) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                checks++;
                if ({miso, busy, done, abort_p} !== 4'b0000 || dbg.state !== IDLE) begin
                    failures++;
                    $display("FAIL reset_mid_outputs: got %b state %0d want 0000 state 0",
                             {miso, busy, done, abort_p}, dbg.state);
                end
                rst = 1'b0;
            end
        join
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after: done=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        read_and_check(4'd3, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            mod_r     = 1'($urandom);
            clk_mod_r = 1'($urandom);
            presc_r   = 8'($urandom);
            chen_r    = 4'($urandom);
            for (int ch = 0; ch < 4; ch++) begin
                cnt_r[ch] = 16'($urandom);
                dac_r[ch] = 8'($urandom);
            end
            read_and_check(4'($urandom_range(0, 15)), "random");
        end
    endtask

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            cnt_r[ch] = 16'h0000;
            dac_r[ch] = 8'h00;
        end
        test_reset();
        test_directed();
        test_snapshot();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
